// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and instruction memory, assembles
// two-word (immediate-carrying) instructions and drives the IF/ID register.
module fetch_stage #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [DATA_WIDTH-1:0] branch_target,
   input  logic                  prog_we,
   input  logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [DATA_WIDTH-1:0] immediate,
   output logic [DATA_WIDTH-1:0] pc_plus_one,
   output logic                  valid
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      RESET_VEC = 2'd0,
      FETCH     = 2'd1,
      FETCH_IMM = 2'd2
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_hold;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [DATA_WIDTH-1:0] w_word;
   logic [DATA_WIDTH-1:0] w_pc_inc;

   // Combinational read; upper PC bits do not take part in addressing
   assign w_word   = r_mem[r_pc[ADDR_WIDTH-1:0]];
   assign w_pc_inc = DATA_WIDTH'(r_pc + DATA_WIDTH'(1));

   // Loader write port; a same-cycle read at this address still sees the old word
   always_ff @(posedge clk) begin
      if (prog_we) begin
         r_mem[prog_addr] <= prog_data;
      end
   end

   // Fetch FSM, PC, hold word and IF/ID register (branch > stall > normal)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= RESET_VEC;
         r_pc        <= '0;
         r_hold      <= '0;
         instruction <= '0;
         immediate   <= '0;
         pc_plus_one <= '0;
         valid       <= 1'b0;
      end else if (branch_taken) begin
         r_state     <= FETCH;
         r_pc        <= branch_target;
         r_hold      <= '0;
         instruction <= '0;
         immediate   <= '0;
         valid       <= 1'b0;
      end else if (!stall) begin
         case (r_state)
            RESET_VEC: begin
               r_pc        <= w_word;
               instruction <= '0;
               immediate   <= '0;
               valid       <= 1'b0;
               r_state     <= FETCH;
            end
            FETCH: begin
               r_pc <= w_pc_inc;
               if (w_word[0]) begin
                  r_hold      <= w_word;
                  instruction <= '0;
                  immediate   <= '0;
                  valid       <= 1'b0;
                  r_state     <= FETCH_IMM;
               end else begin
                  instruction <= w_word;
                  immediate   <= '0;
                  pc_plus_one <= w_pc_inc;
                  valid       <= 1'b1;
               end
            end
            FETCH_IMM: begin
               r_pc        <= w_pc_inc;
               instruction <= r_hold;
               immediate   <= w_word;
               pc_plus_one <= w_pc_inc;
               valid       <= 1'b1;
               r_state     <= FETCH;
            end
            default: begin
               r_state <= RESET_VEC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed cycles push expected IF/ID
// contents, an independent monitor pops and compares after each edge.
module tb_fetch_stage;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 11;

   typedef struct packed {
      logic [DW-1:0] instr;
      logic [DW-1:0] imm;
      logic [DW-1:0] ppo;
      logic          vld;
   } ifid_t;

   logic          clk;
   logic          rst;
   logic          stall;
   logic          branch_taken;
   logic [DW-1:0] branch_target;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic [DW-1:0] instruction;
   logic [DW-1:0] immediate;
   logic [DW-1:0] pc_plus_one;
   logic          valid;

   ifid_t exp_q[$];
   int    n_vec;
   int    n_err;
   int    cyc_no;
   bit    stim_done;

   fetch_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .prog_we       (prog_we),
      .prog_addr     (prog_addr),
      .prog_data     (prog_data),
      .instruction   (instruction),
      .immediate     (immediate),
      .pc_plus_one   (pc_plus_one),
      .valid         (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string name, input ifid_t exp);
      ifid_t act;
      act = '{instr: instruction, imm: immediate, ppo: pc_plus_one, vld: valid};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got instr=%h imm=%h ppo=%h valid=%b, want instr=%h imm=%h ppo=%h valid=%b",
                  name, act.instr, act.imm, act.ppo, act.vld,
                  exp.instr, exp.imm, exp.ppo, exp.vld);
      end
   endtask

   // Monitor: one expectation per edge on which stimulus queued one
   initial begin
      cyc_no = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc_no++;
         if (exp_q.size() > 0) begin
            ifid_t e;
            e = exp_q.pop_front();
            compare($sformatf("edge%0d", cyc_no), e);
         end
      end
   end

   // Called at a falling edge; returns at the next falling edge
   task automatic cyc(input logic st, input logic br, input logic [DW-1:0] tgt,
                      input logic [DW-1:0] ei, input logic [DW-1:0] em,
                      input logic [DW-1:0] ep, input logic ev);
      stall         = st;
      branch_taken  = br;
      branch_target = tgt;
      exp_q.push_back('{instr: ei, imm: em, ppo: ep, vld: ev});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      @(posedge clk);
      @(negedge clk);
      prog_we   = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0; stim_done = 1'b0;
      rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      @(negedge clk);
      #1;
      compare("reset_state", '0);

      load(11'h000, 16'h0020);
      load(11'h020, 16'h1000);
      load(11'h021, 16'h2001);
      load(11'h022, 16'h0005);
      load(11'h023, 16'h3000);
      load(11'h024, 16'h4001);
      load(11'h025, 16'h0007);
      load(11'h026, 16'h5000);
      load(11'h027, 16'h6001);
      load(11'h028, 16'hEEEE);
      load(11'h040, 16'h7000);
      load(11'h041, 16'h8000);
      load(11'h050, 16'h9000);
      load(11'h7FF, 16'hA000);

      rst = 1'b1;
      //  stall br  target    instr     imm       ppo       valid
      cyc(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0); // reset vector load
      cyc(0, 0, 16'h0000, 16'h1000, 16'h0000, 16'h0021, 1); // first single word
      cyc(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0021, 0); // 0x2001 held
      cyc(0, 0, 16'h0000, 16'h2001, 16'h0005, 16'h0023, 1); // pair
      cyc(0, 0, 16'h0000, 16'h3000, 16'h0000, 16'h0024, 1);
      cyc(1, 0, 16'h0000, 16'h3000, 16'h0000, 16'h0024, 1); // stall in FETCH
      cyc(1, 0, 16'h0000, 16'h3000, 16'h0000, 16'h0024, 1);
      cyc(1, 0, 16'h0000, 16'h3000, 16'h0000, 16'h0024, 1);
      cyc(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0024, 0); // 0x4001 held
      cyc(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0024, 0); // stall in FETCH_IMM
      cyc(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0024, 0);
      cyc(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0024, 0);
      cyc(0, 0, 16'h0000, 16'h4001, 16'h0007, 16'h0026, 1); // pair survives stall
      cyc(0, 0, 16'h0000, 16'h5000, 16'h0000, 16'h0027, 1);
      cyc(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0027, 0); // 0x6001 held
      cyc(0, 1, 16'h0040, 16'h0000, 16'h0000, 16'h0027, 0); // branch mid-pair
      cyc(0, 0, 16'h0000, 16'h7000, 16'h0000, 16'h0041, 1);
      cyc(1, 1, 16'h0050, 16'h0000, 16'h0000, 16'h0041, 0); // branch wins over stall
      cyc(0, 0, 16'h0000, 16'h9000, 16'h0000, 16'h0051, 1);
      cyc(0, 1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0051, 0); // branch to top
      cyc(0, 0, 16'h0000, 16'hA000, 16'h0000, 16'h0000, 1); // pc+1 wraps
      cyc(0, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0001, 1); // fetched from addr 0

      // Asynchronous reset between edges
      #2;
      rst = 1'b0;
      #1;
      compare("async_reset", '0);
      @(negedge clk);
      compare("reset_held", '0);
      rst = 1'b1;
      cyc(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
      cyc(0, 0, 16'h0000, 16'h1000, 16'h0000, 16'h0021, 1); // restart from vector

      // Branch taken while still in RESET_VEC
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      cyc(0, 1, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 0);
      cyc(0, 0, 16'h0000, 16'h7000, 16'h0000, 16'h0041, 1);
      cyc(0, 0, 16'h0000, 16'h8000, 16'h0000, 16'h0042, 1);

      @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
      end
      stim_done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit
   initial begin
      #100000;
      if (!stim_done) begin
         $display("FAIL timeout: got no completion, want completion before limit");
         $fatal(1, "timeout");
      end
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined processor. It sits directly upstream of `decode_stage` and owns the PC and the instruction memory. It fetches one 16-bit word per cycle and assembles two-word (immediate-carrying) instructions. It presents the result to decode through the IF/ID pipeline register, with stall and branch-redirect control from the hazard/branch logic.

## Interface
Parameters:
- `DATA_WIDTH`, 16: instruction word and PC width
- `ADDR_WIDTH`, 11: instruction memory address bits (2048 words)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold PC, FSM, hold register and IF/ID contents
- `branch_taken`  in  1  redirect PC and flush IF/ID
- `branch_target`  in  16  new PC when `branch_taken`=1
- `prog_we`  in  1  synchronous instruction-memory write enable (bench/loader)
- `prog_addr`  in  ADDR_WIDTH  write address
- `prog_data`  in  16  write data
- `instruction`  out  16  IF/ID: first instruction word
- `immediate`  out  16  IF/ID: second word for two-word instructions, else 0
- `pc_plus_one`  out  16  IF/ID: address following the last word consumed
- `valid`  out  1  IF/ID: 1 = real instruction, 0 = bubble (NOP)

## Operation
- Memory: 2^ADDR_WIDTH x 16 array, combinational read at `pc[ADDR_WIDTH-1:0]`, synchronous write via `prog_*`. Write and read at the same address in the same cycle: the read returns the old word. No reset of array contents.
- Immediate flag: fetched word bit 0 = 1 means the next word is its immediate.
- Bubble: `instruction`=0, `immediate`=0, `valid`=0, `pc_plus_one` unchanged.
- FSM states:
  - RESET_VEC (reset state): `pc` <= imem[0], IF/ID <= bubble -> FETCH.
  - FETCH: word w = imem[pc]; `pc` <= pc+1.
    - w[0]=0: IF/ID <= {w, 0, pc+1, valid=1}; stay in FETCH.
    - w[0]=1: hold <= w; IF/ID <= bubble -> FETCH_IMM.
  - FETCH_IMM: IF/ID <= {hold, imem[pc], pc+1, valid=1}; `pc` <= pc+1 -> FETCH.
- Priority per edge: reset > `branch_taken` > `stall` > normal.
  - `branch_taken`: `pc` <= `branch_target`; IF/ID <= bubble; hold discarded; state -> FETCH, from any state including RESET_VEC.
  - `stall` (no branch): every register holds its value; no word is consumed or lost.
- Arithmetic: `pc` is 16-bit, and pc+1 wraps 0xFFFF -> 0x0000. Upper PC bits above ADDR_WIDTH are ignored for addressing but kept in `pc_plus_one`.

## Timing
- Reset (`rst`=0, asynchronous, effective immediately, including mid-instruction):
  - `instruction`=0, `immediate`=0, `pc_plus_one`=0, `valid`=0.
  - Internal `pc`=0, hold=0, state=RESET_VEC.
- After `rst` rises, edge 1 loads the reset vector. Edge 2 produces the first valid single-word instruction.
- Latency:
  - Single-word instruction: 1 cycle (word at PC on edge n appears on IF/ID after edge n).
  - Two-word instruction: 2 cycles, with a bubble on the first.
- Throughput: 1 single-word instruction/cycle; 1 two-word instruction/2 cycles.
- `stall` and `branch_*` are sampled at the rising edge. A `branch_taken` asserted while the stall is held still redirects on that edge.

## Test plan
- Reset vector: imem[0]=0x0020, imem[0x20]=0x1000, release `rst` -> edge 1 `valid`=0; edge 2 `instruction`=0x1000, `immediate`=0, `pc_plus_one`=0x0021, `valid`=1.
- Two-word: imem[0x20]=0x2001, imem[0x21]=0x0005, imem[0x22]=0x3000 -> edge 2 `valid`=0; edge 3 `instruction`=0x2001, `immediate`=0x0005, `pc_plus_one`=0x0022; edge 4 `instruction`=0x3000, `pc_plus_one`=0x0023.
- Stall: assert `stall` 3 cycles, once in FETCH and once in FETCH_IMM -> IF/ID frozen during the stall. After release the stream continues with no duplicated or skipped word, and the immediate still pairs correctly.
- Branch mid-pair: `branch_taken`=1, `branch_target`=0x0040 during FETCH_IMM -> next edge `valid`=0 and the held word is dropped; following edge `instruction`=imem[0x40], `pc_plus_one`=0x0041.
- Simultaneous `stall`=1 and `branch_taken`=1, target 0x0050 -> redirect happens: bubble, then imem[0x50].
- Async reset mid-stream (drop `rst` between edges) -> all outputs 0 without a clock edge; restart from the reset vector. PC wrap: branch to 0xFFFF with a single-word instruction there -> `pc_plus_one`=0x0000, next fetch from address 0.
